navegador_malha: RTL and testbench

Mission sequencer on the initiator side of the nearest-target search (`distancias`). It supplies the robot position and quadrant mask, pulses `novoDado` and waits for `operacaoFinalizada`. It then walks the robot to `destinoX`/`destinoY` one cell per motor handshake and marks the reached cell visited in the grid memory. It repeats the search until no target remains, a timeout occurs, or the mission is aborted.

---
 rtl/navegador_malha_if.sv | 46 ++++
 rtl/navegador_malha.sv | 211 +++++++++++++++++++++
 tb/tb_navegador_malha.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/navegador_malha_if.sv
// Mission bus between the grid navigator and its environment:
// start/abort, search request/result, motor step handshake and grid write port.
interface navegador_malha_if #(
  parameter int TamanhoMalha     = 8,
  parameter int tamanhoDistancia = 8
);
  localparam int EndW = $clog2(TamanhoMalha * TamanhoMalha);

  logic                        iniciar;
  logic                        abortar;
  logic [tamanhoDistancia-1:0] posicaoInicialX;
  logic [tamanhoDistancia-1:0] posicaoInicialY;
  logic [3:0]                  enableQuadrantes;
  logic [tamanhoDistancia-1:0] posicaoAtualnoEixoX;
  logic [tamanhoDistancia-1:0] posicaoAtualnoEixoY;
  logic [3:0]                  enable;
  logic                        novoDado;
  logic                        operacaoFinalizada;
  logic [tamanhoDistancia-1:0] destinoX;
  logic [tamanhoDistancia-1:0] destinoY;
  logic                        passoValido;
  logic [1:0]                  passoDirecao;
  logic                        passoConcluido;
  logic                        malhaWrEn;
  logic [EndW-1:0]             malhaWrEndereco;
  logic [1:0]                  malhaWrDado;
  logic                        ocupado;
  logic                        semAlvo;
  logic                        erroTimeout;

  modport master (
    input  iniciar, abortar, posicaoInicialX, posicaoInicialY, enableQuadrantes,
    input  operacaoFinalizada, destinoX, destinoY, passoConcluido,
    output posicaoAtualnoEixoX, posicaoAtualnoEixoY, enable, novoDado,
    output passoValido, passoDirecao, malhaWrEn, malhaWrEndereco, malhaWrDado,
    output ocupado, semAlvo, erroTimeout
  );

  modport slave (
    output iniciar, abortar, posicaoInicialX, posicaoInicialY, enableQuadrantes,
    output operacaoFinalizada, destinoX, destinoY, passoConcluido,
    input  posicaoAtualnoEixoX, posicaoAtualnoEixoY, enable, novoDado,
    input  passoValido, passoDirecao, malhaWrEn, malhaWrEndereco, malhaWrDado,
    input  ocupado, semAlvo, erroTimeout
  );
endinterface

// File: rtl/navegador_malha.sv
// Mission sequencer: requests a nearest-target search, walks the robot there one
// cell per motor handshake, marks the cell visited and repeats until no target remains.
module navegador_malha #(
  parameter int TamanhoMalha     = 8,
  parameter int tamanhoDistancia = 8,
  parameter int timeoutBusca     = 4096
) (
  input  logic               clock,
  input  logic               reset,
  navegador_malha_if.master  bus
);
  localparam int EndW  = $clog2(TamanhoMalha * TamanhoMalha);
  localparam int ContW = $clog2(timeoutBusca + 1);
  localparam int LargW = 2 * tamanhoDistancia;

  localparam logic [tamanhoDistancia-1:0] LIMITE   = tamanhoDistancia'(TamanhoMalha);
  localparam logic [tamanhoDistancia-1:0] UM       = tamanhoDistancia'(1);
  localparam logic [LargW-1:0]            LARGURA  = LargW'(TamanhoMalha);
  localparam logic [ContW-1:0]            CONT_FIM = ContW'(timeoutBusca - 1);
  localparam logic [ContW-1:0]            CONT_UM  = ContW'(1);

  localparam logic [1:0] DIR_MAIS_X  = 2'b00;
  localparam logic [1:0] DIR_MENOS_X = 2'b01;
  localparam logic [1:0] DIR_MAIS_Y  = 2'b10;
  localparam logic [1:0] DIR_MENOS_Y = 2'b11;

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    DISPARO      = 3'd1,
    AGUARDA      = 3'd2,
    MOVE         = 3'd3,
    ESPERA_PASSO = 3'd4,
    MARCA        = 3'd5
  } estado_t;

  estado_t                     estado_q, estado_d;
  logic [tamanhoDistancia-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [tamanhoDistancia-1:0] dest_x_q, dest_x_d, dest_y_q, dest_y_d;
  logic [3:0]                  enable_q, enable_d;
  logic                        fin_ant_q, fin_ant_d;
  logic [ContW-1:0]            cont_q, cont_d;
  logic                        novo_dado_q, novo_dado_d;
  logic                        passo_valido_q, passo_valido_d;
  logic [1:0]                  passo_dir_q, passo_dir_d;
  logic                        wr_en_q, wr_en_d;
  logic [EndW-1:0]             wr_end_q, wr_end_d;
  logic                        sem_alvo_q, sem_alvo_d;
  logic                        erro_timeout_q, erro_timeout_d;
  logic                        ocupado_q, ocupado_d;
  logic                        borda_s;
  logic                        sem_alvo_cond_s;
  logic [LargW-1:0]            end_completo_s;

  assign borda_s        = bus.operacaoFinalizada & ~fin_ant_q;
  assign end_completo_s = LargW'(pos_x_q) + (LargW'(pos_y_q) * LARGURA);
  assign sem_alvo_cond_s = (bus.destinoX >= LIMITE) || (bus.destinoY >= LIMITE) ||
                           ((bus.destinoX == pos_x_q) && (bus.destinoY == pos_y_q));

  // Next-state and next-output logic; abort overrides every transition.
  always_comb begin
    estado_d       = estado_q;
    pos_x_d        = pos_x_q;
    pos_y_d        = pos_y_q;
    dest_x_d       = dest_x_q;
    dest_y_d       = dest_y_q;
    enable_d       = enable_q;
    fin_ant_d      = bus.operacaoFinalizada;
    cont_d         = cont_q;
    novo_dado_d    = 1'b0;
    passo_valido_d = passo_valido_q;
    passo_dir_d    = passo_dir_q;
    wr_en_d        = 1'b0;
    wr_end_d       = wr_end_q;
    sem_alvo_d     = sem_alvo_q;
    erro_timeout_d = erro_timeout_q;

    if (bus.abortar) begin
      estado_d       = OCIOSO;
      passo_valido_d = 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (bus.iniciar) begin
            pos_x_d        = bus.posicaoInicialX;
            pos_y_d        = bus.posicaoInicialY;
            enable_d       = bus.enableQuadrantes;
            sem_alvo_d     = 1'b0;
            erro_timeout_d = 1'b0;
            novo_dado_d    = 1'b1;
            estado_d       = DISPARO;
          end else begin
            estado_d = OCIOSO;
          end
        end
        DISPARO: begin
          cont_d   = '0;
          estado_d = AGUARDA;
        end
        AGUARDA: begin
          if (borda_s) begin
            dest_x_d = bus.destinoX;
            dest_y_d = bus.destinoY;
            if (sem_alvo_cond_s) begin
              sem_alvo_d = 1'b1;
              estado_d   = OCIOSO;
            end else begin
              estado_d = MOVE;
            end
          end else if (cont_q == CONT_FIM) begin
            erro_timeout_d = 1'b1;
            estado_d       = OCIOSO;
          end else begin
            cont_d = cont_q + CONT_UM;
          end
        end
        MOVE: begin
          // X is resolved fully before Y is touched.
          if (pos_x_q != dest_x_q) begin
            passo_dir_d    = (pos_x_q < dest_x_q) ? DIR_MAIS_X : DIR_MENOS_X;
            passo_valido_d = 1'b1;
            estado_d       = ESPERA_PASSO;
          end else if (pos_y_q != dest_y_q) begin
            passo_dir_d    = (pos_y_q < dest_y_q) ? DIR_MAIS_Y : DIR_MENOS_Y;
            passo_valido_d = 1'b1;
            estado_d       = ESPERA_PASSO;
          end else begin
            wr_en_d  = 1'b1;
            wr_end_d = end_completo_s[EndW-1:0];
            estado_d = MARCA;
          end
        end
        ESPERA_PASSO: begin
          if (bus.passoConcluido) begin
            case (passo_dir_q)
              DIR_MAIS_X:  pos_x_d = pos_x_q + UM;
              DIR_MENOS_X: pos_x_d = pos_x_q - UM;
              DIR_MAIS_Y:  pos_y_d = pos_y_q + UM;
              default:     pos_y_d = pos_y_q - UM;
            endcase
            passo_valido_d = 1'b0;
            estado_d       = MOVE;
          end else begin
            estado_d = ESPERA_PASSO;
          end
        end
        MARCA: begin
          novo_dado_d = 1'b1;
          estado_d    = DISPARO;
        end
        default: begin
          passo_valido_d = 1'b0;
          estado_d       = OCIOSO;
        end
      endcase
    end

    ocupado_d = (estado_d != OCIOSO);
  end

  // State and registered-output flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      pos_x_q        <= '0;
      pos_y_q        <= '0;
      dest_x_q       <= '0;
      dest_y_q       <= '0;
      enable_q       <= 4'd0;
      fin_ant_q      <= 1'b0;
      cont_q         <= '0;
      novo_dado_q    <= 1'b0;
      passo_valido_q <= 1'b0;
      passo_dir_q    <= 2'b00;
      wr_en_q        <= 1'b0;
      wr_end_q       <= '0;
      sem_alvo_q     <= 1'b0;
      erro_timeout_q <= 1'b0;
      ocupado_q      <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      dest_x_q       <= dest_x_d;
      dest_y_q       <= dest_y_d;
      enable_q       <= enable_d;
      fin_ant_q      <= fin_ant_d;
      cont_q         <= cont_d;
      novo_dado_q    <= novo_dado_d;
      passo_valido_q <= passo_valido_d;
      passo_dir_q    <= passo_dir_d;
      wr_en_q        <= wr_en_d;
      wr_end_q       <= wr_end_d;
      sem_alvo_q     <= sem_alvo_d;
      erro_timeout_q <= erro_timeout_d;
      ocupado_q      <= ocupado_d;
    end
  end

  assign bus.posicaoAtualnoEixoX = pos_x_q;
  assign bus.posicaoAtualnoEixoY = pos_y_q;
  assign bus.enable              = enable_q;
  assign bus.novoDado            = novo_dado_q;
  assign bus.passoValido         = passo_valido_q;
  assign bus.passoDirecao        = passo_dir_q;
  assign bus.malhaWrEn           = wr_en_q;
  assign bus.malhaWrEndereco     = wr_end_q;
  assign bus.malhaWrDado         = 2'b01;
  assign bus.ocupado             = ocupado_q;
  assign bus.semAlvo             = sem_alvo_q;
  assign bus.erroTimeout         = erro_timeout_q;
endmodule

// File: tb/tb_navegador_malha.sv
// Directed bench for navegador_malha: expected steps and grid writes are queued
// when a search result is driven and checked as the DUT produces them.
module tb_navegador_malha;
  localparam int TM = 8;
  localparam int TD = 8;
  localparam int TO = 16;
  localparam int LIM_ESPERA = 40;

  logic clock = 1'b0;
  logic reset = 1'b1;

  navegador_malha_if #(.TamanhoMalha(TM), .tamanhoDistancia(TD)) bus ();

  navegador_malha #(.TamanhoMalha(TM), .tamanhoDistancia(TD), .timeoutBusca(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_dir_q[$];
  int         exp_end_q[$];
  int         mx = 0;
  int         my = 0;
  int         n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag);
    chk(tag, 32'({bus.posicaoAtualnoEixoX, bus.posicaoAtualnoEixoY}), 32'({mx[7:0], my[7:0]}));
  endtask

  task automatic chk_zeros(input string tag);
    chk(tag, 32'({bus.posicaoAtualnoEixoX, bus.posicaoAtualnoEixoY, bus.enable, bus.novoDado,
                  bus.passoValido, bus.passoDirecao, bus.malhaWrEn, bus.malhaWrEndereco,
                  bus.ocupado, bus.semAlvo, bus.erroTimeout}), 32'd0);
  endtask

  task automatic espera_passo(output int ciclos);
    ciclos = 0;
    while (bus.passoValido !== 1'b1 && ciclos < LIM_ESPERA) begin
      @(negedge clock);
      ciclos++;
    end
  endtask

  task automatic inicia(input logic [7:0] x, input logic [7:0] y, input logic [3:0] m);
    bus.posicaoInicialX  = x;
    bus.posicaoInicialY  = y;
    bus.enableQuadrantes = m;
    bus.iniciar          = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    mx = int'(x);
    my = int'(y);
    chk("ini_novo_dado", 32'(bus.novoDado), 32'd1);
    chk("ini_ocupado", 32'(bus.ocupado), 32'd1);
    chk("ini_enable", 32'(bus.enable), 32'(m));
    chk("ini_flags", 32'({bus.semAlvo, bus.erroTimeout}), 32'd0);
    chk_pos("ini_pos");
    @(negedge clock);
    chk("ini_novo_pulso", 32'(bus.novoDado), 32'd0);
  endtask

  task automatic executa_passos();
    int c;
    logic [1:0] d;
    while (exp_dir_q.size() > 0) begin
      espera_passo(c);
      chk("passo_chegou", 32'(c < LIM_ESPERA), 32'd1);
      d = exp_dir_q.pop_front();
      chk("passo_dir", 32'(bus.passoDirecao), 32'(d));
      @(negedge clock);
      chk("passo_estavel", 32'({bus.passoValido, bus.passoDirecao}), 32'({1'b1, d}));
      bus.passoConcluido = 1'b1;
      case (d)
        2'b00:   mx++;
        2'b01:   mx--;
        2'b10:   my++;
        default: my--;
      endcase
      @(negedge clock);
      bus.passoConcluido = 1'b0;
      chk("passo_baixou", 32'(bus.passoValido), 32'd0);
      chk_pos("passo_pos");
    end
  endtask

  task automatic verifica_escrita();
    int e;
    @(negedge clock);
    e = (exp_end_q.size() > 0) ? exp_end_q.pop_front() : -1;
    chk("wr_en", 32'(bus.malhaWrEn), 32'd1);
    chk("wr_end", 32'(bus.malhaWrEndereco), e);
    chk("wr_dado", 32'(bus.malhaWrDado), 32'd1);
    chk_pos("wr_pos");
    @(negedge clock);
    chk("wr_pulso", 32'(bus.malhaWrEn), 32'd0);
    chk("novo_dado_rep", 32'(bus.novoDado), 32'd1);
  endtask

  initial begin
    bus.iniciar            = 1'b0;
    bus.abortar            = 1'b0;
    bus.posicaoInicialX    = 8'd0;
    bus.posicaoInicialY    = 8'd0;
    bus.enableQuadrantes   = 4'd0;
    bus.operacaoFinalizada = 1'b0;
    bus.destinoX           = 8'd0;
    bus.destinoY           = 8'd0;
    bus.passoConcluido     = 1'b0;

    // reset state
    #2;
    chk_zeros("reset_saidas");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("pos_reset_ocioso", 32'(bus.ocupado), 32'd0);

    // (3,3) -> (2,6): -X, +Y, +Y, +Y, write 50
    inicia(8'd3, 8'd3, 4'hF);
    bus.operacaoFinalizada = 1'b1;
    bus.destinoX = 8'd2;
    bus.destinoY = 8'd6;
    exp_dir_q.push_back(2'b01);
    exp_dir_q.push_back(2'b10);
    exp_dir_q.push_back(2'b10);
    exp_dir_q.push_back(2'b10);
    exp_end_q.push_back(50);
    espera_passo(n);
    chk("latencia_1o_passo", n, 32'd2);
    bus.operacaoFinalizada = 1'b0;
    executa_passos();
    verifica_escrita();

    // destination equals current cell -> no target
    @(negedge clock);
    bus.operacaoFinalizada = 1'b1;
    @(negedge clock);
    chk("sem_alvo_igual", 32'({bus.semAlvo, bus.ocupado}), 32'b10);
    chk("sem_alvo_sem_acao", 32'({bus.passoValido, bus.malhaWrEn}), 32'd0);
    @(negedge clock);
    chk("sem_alvo_parado", 32'({bus.passoValido, bus.malhaWrEn, bus.ocupado}), 32'd0);
    bus.operacaoFinalizada = 1'b0;

    // out-of-range destination -> no target
    inicia(8'd2, 8'd6, 4'hF);
    bus.operacaoFinalizada = 1'b1;
    bus.destinoX = 8'd8;
    bus.destinoY = 8'd1;
    @(negedge clock);
    chk("sem_alvo_fora", 32'({bus.semAlvo, bus.ocupado, bus.passoValido}), 32'b100);
    chk_pos("sem_alvo_fora_pos");
    bus.operacaoFinalizada = 1'b0;

    // search timeout
    inicia(8'd1, 8'd1, 4'h3);
    repeat (15) @(negedge clock);
    chk("timeout_antes", 32'({bus.erroTimeout, bus.ocupado}), 32'b01);
    @(negedge clock);
    chk("timeout_set", 32'({bus.erroTimeout, bus.ocupado, bus.semAlvo}), 32'b100);

    // level already high on entry is ignored; fresh edge to (5,3)
    bus.operacaoFinalizada = 1'b1;
    bus.destinoX = 8'd5;
    bus.destinoY = 8'd3;
    inicia(8'd3, 8'd3, 4'hA);
    repeat (3) begin
      @(negedge clock);
      chk("nivel_ignorado", 32'({bus.passoValido, bus.ocupado}), 32'b01);
    end
    bus.operacaoFinalizada = 1'b0;
    @(negedge clock);
    bus.operacaoFinalizada = 1'b1;
    exp_dir_q.push_back(2'b00);
    exp_dir_q.push_back(2'b00);
    exp_end_q.push_back(29);
    executa_passos();
    verifica_escrita();

    // abort in ESPERA_PASSO together with passoConcluido
    @(negedge clock);
    bus.operacaoFinalizada = 1'b0;
    @(negedge clock);
    bus.operacaoFinalizada = 1'b1;
    bus.destinoX = 8'd5;
    bus.destinoY = 8'd5;
    espera_passo(n);
    chk("aborta_passo_dir", 32'({bus.passoValido, bus.passoDirecao}), 32'b110);
    bus.abortar        = 1'b1;
    bus.passoConcluido = 1'b1;
    @(negedge clock);
    bus.passoConcluido = 1'b0;
    chk("aborta_saidas", 32'({bus.ocupado, bus.passoValido}), 32'd0);
    chk_pos("aborta_pos");
    // abort beats iniciar in OCIOSO
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    bus.abortar = 1'b0;
    chk("aborta_vs_iniciar", 32'({bus.ocupado, bus.novoDado}), 32'd0);
    chk_pos("aborta_pos_mantida");

    // async reset mid-step, then clean restart from (0,7)
    bus.operacaoFinalizada = 1'b0;
    inicia(8'd0, 8'd0, 4'h5);
    bus.operacaoFinalizada = 1'b1;
    bus.destinoX = 8'd0;
    bus.destinoY = 8'd2;
    espera_passo(n);
    chk("reset_passo_ativo", 32'({bus.passoValido, bus.passoDirecao}), 32'b110);
    reset = 1'b1;
    #1;
    chk_zeros("reset_assincrono");
    @(negedge clock);
    reset = 1'b0;
    bus.operacaoFinalizada = 1'b0;
    @(negedge clock);
    chk_zeros("reset_liberado");
    inicia(8'd0, 8'd7, 4'hF);
    bus.operacaoFinalizada = 1'b1;
    bus.destinoX = 8'd1;
    bus.destinoY = 8'd7;
    exp_dir_q.push_back(2'b00);
    exp_end_q.push_back(57);
    executa_passos();
    verifica_escrita();
    chk("fila_vazia", 32'(exp_dir_q.size() + exp_end_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
